// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one signed-by-unsigned shift-add multiplier among NREQ requesters.
// Latency: grant to resp_valid is 1 + (cycles to collect WIDTH mult_en pulses); grant is combinational in IDLE.
// Backpressure: requesters hold req_valid until req_ready; only one operation in flight, others wait in IDLE.
module mult_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mult_en,
    input  logic                  sample_tick,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [2*WIDTH-1:0]    resp_p,
    output logic                  busy,
    output logic                  overrun
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand_idx;
    logic [IW-1:0]   ptr_nxt;
    logic            gnt_found;
    int              cand;
    logic [PW-1:0]   a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_sum;
    logic [SW-1:0]   step;
    logic            last_step;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = IW'(cand);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Operand mux, pointer advance and one accumulate step
    always_comb begin
        a_sel     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        b_sel     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        ptr_nxt   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        acc_sum   = b_sh[0] ? acc + a_sh : acc;
        last_step = (step == SW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE grants, CALC runs WIDTH enabled steps, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = CALC;
            CALC:    if (mult_en && last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: grant is combinational in IDLE and masked during reset so it reads 0 immediately
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state != IDLE);
        if (state == IDLE && gnt_found && !rst) req_ready = NREQ'(1) << gnt_idx;
        if (state == DONE) resp_valid = NREQ'(1) << owner;
    end

    // Datapath: operand latch on grant, shift-add while enabled, result and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            owner   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            step    <= '0;
            resp_p  <= '0;
            overrun <= 1'b0;
        end else begin
            if (state == IDLE && gnt_found) begin
                owner  <= gnt_idx;
                rr_ptr <= ptr_nxt;
                a_sh   <= {{WIDTH{a_sel[WIDTH-1]}}, a_sel};
                b_sh   <= b_sel;
                acc    <= '0;
                step   <= '0;
            end else if (state == CALC && mult_en) begin
                acc  <= acc_sum;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                step <= step + 1'b1;
                // resp_p changes on the same edge that enters DONE
                if (last_step) resp_p <= acc_sum;
            end
            if (sample_tick && (state != IDLE || (|req_valid))) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: products, latency, slow enable, overrun, reset abort, round-robin.
// Latency: checks the exact grant-to-response cycle count with mult_en tied high.
// Backpressure: requesters hold req_valid until req_ready and re-request only after resp_valid.
module tb_mult_arbiter;

    localparam int W = 16;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            mult_en;
    logic            sample_tick;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [2*W-1:0]  resp_p;
    logic            busy;
    logic            overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit slow_en = 1'b0;
    int en_cnt  = 0;

    mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .mult_en(mult_en), .sample_tick(sample_tick),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_p(resp_p),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // mult_en changes on the falling edge so the DUT and the bench see the same level at posedge
    initial begin
        mult_en = 1'b1;
        forever begin
            @(negedge clk);
            en_cnt++;
            mult_en = slow_en ? (en_cnt % 4 == 0) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction from requester idx; called at posedge+1 with the DUT in IDLE.
    // exp_lat > 0 demands an exact latency, 0 accepts the 1-in-4 enable window.
    // tick_at > 0 pulses sample_tick during that cycle after the grant.
    task automatic do_mult(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp_p, input int exp_lat, input int tick_at);
        int  cyc;
        int  pulses;
        bit  got;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx]    = 1'b1;
        #1;
        check("grant", req_ready, 64'(1 << idx));
        check("busy_at_grant", busy, 0);
        cyc = 0; pulses = 0; got = 1'b0;
        while (cyc < 400 && !got) begin
            @(posedge clk);
            cyc++;
            if (cyc >= 2) pulses += int'(mult_en);
            #1;
            sample_tick = (cyc == tick_at);
            if (cyc == 1) begin
                req_valid[idx] = 1'b0;
                check("busy_after_grant", busy, 1);
            end
            if (resp_valid != 0) got = 1'b1;
        end
        sample_tick = 1'b0;
        check("resp_valid", resp_valid, 64'(1 << idx));
        check("resp_p", resp_p, exp_p);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        else begin
            check("enable_pulses", pulses, 16);
            check("slow_latency_window", (cyc >= 61 && cyc <= 68), 1);
        end
        @(posedge clk); #1;
        check("resp_single_pulse", resp_valid, 0);
        check("resp_p_stable", resp_p, exp_p);
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    int  gcount, rcount, cyc, pend, saw;
    int  order [6];
    logic [W-1:0] rr_a [N];

    initial begin
        rst = 1'b1; sample_tick = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tick in IDLE with no requests is a clean frame
        pulse_tick();
        check("idle_tick_no_overrun", overrun, 0);

        do_mult(0, 16'd3, 16'd5, 32'd15, 17, 0);
        do_mult(1, 16'h8000, 16'hFFFF, 32'h80008000, 17, 0);
        do_mult(2, 16'hFFFF, 16'd1, 32'hFFFFFFFF, 17, 0);

        slow_en = 1'b1;
        do_mult(0, 16'd100, 16'd200, 32'd20000, 0, 0);
        slow_en = 1'b0;
        @(posedge clk); #1;

        // Tick while CALC is running flags an overrun that stays sticky
        do_mult(1, 16'd9, 16'd9, 32'd81, 17, 5);
        check("overrun_set", overrun, 1);
        pulse_tick();
        check("overrun_sticky", overrun, 1);

        // Reset at CALC step 7 aborts with no response
        req_a[0 +: W] = 16'd5; req_b[0 +: W] = 16'd3; req_valid[0] = 1'b1;
        #1;
        check("abort_grant", req_ready, 1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_p", resp_p, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 0;
        repeat (20) begin @(posedge clk); #1; if (resp_valid != 0) saw++; end
        check("abort_no_resp", saw, 0);
        do_mult(2, 16'd7, 16'd6, 32'd42, 17, 0);

        // Round-robin with all three requesters contending
        do_reset();
        rr_a[0] = 16'd11; rr_a[1] = 16'd22; rr_a[2] = 16'd33;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = rr_a[i];
            req_b[i*W +: W] = 16'd1;
        end
        req_valid = '1;
        gcount = 0; rcount = 0; cyc = 0; pend = -1;
        #1;
        while (rcount < 6 && cyc < 400) begin
            if (req_ready != 0) begin
                check("rr_onehot", $countones(req_ready), 1);
                for (int i = 0; i < N; i++)
                    if (req_ready[i] && gcount < 6) begin
                        order[gcount] = i;
                        gcount++;
                        pend = i;
                    end
            end
            @(posedge clk); #1;
            cyc++;
            if (pend >= 0) begin req_valid[pend] = 1'b0; pend = -1; end
            if (resp_valid != 0) begin
                check("rr_resp_onehot", $countones(resp_valid), 1);
                for (int i = 0; i < N; i++)
                    if (resp_valid[i]) begin
                        check("rr_resp_p", resp_p, 64'(rr_a[i]));
                        req_valid[i] = 1'b1;
                    end
                rcount++;
                if (rcount == 6) req_valid = '0;
            end
            #1;
        end
        req_valid = '0;
        check("rr_responses", rcount, 6);
        check("rr_grants", gcount, 6);
        for (int k = 0; k < 6; k++) check("rr_order", order[k], k % 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Time-shares one iterative shift-add multiplier between up to NREQ synthesizer requesters, such as the oscillator amplitude path, the ADSR envelope scaling and the output mixer. It sits behind `clkdiv`: the multiplier advances one bit per `clk_mult` enable pulse, and `clk_sample` marks the start of each audio sample frame. Grants are round-robin. A sticky overrun flag reports frames in which the multiply workload did not finish before the next sample.

## Interface
- `WIDTH`, default 16: operand width; the product is 2*WIDTH bits.
- `NREQ`, default 3: number of requesters, 2..8.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mult_en`  in  1: multiplier step enable, from `clkdiv` `clk_mult`, sampled as a level each `clk` cycle.
- `sample_tick`  in  1: frame start, from `clkdiv` `clk_sample`, single-cycle pulse.
- `req_valid`  in  NREQ: per-requester request.
- `req_a`  in  NREQ*WIDTH: multiplicand, signed two's complement; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH: multiplier, unsigned; same slicing as `req_a`.
- `req_ready`  out  NREQ: one-hot grant/accept pulse.
- `resp_valid`  out  NREQ: one-hot result pulse.
- `resp_p`  out  2*WIDTH: signed product of the most recently completed operation.
- `busy`  out  1: high in any state other than IDLE.
- `overrun`  out  1: sticky frame-overrun flag.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE:**
  - If any `req_valid` bit is high, grant the first valid index at or after `rr_ptr`, searching upward with wrap.
  - In the same cycle, assert `req_ready[g]`, latch a=`req_a[g]` and b=`req_b[g]`, clear the accumulator and step count, and go to CALC.
  - Set `rr_ptr` to (g+1) mod NREQ.
- **Handshake:**
  - A transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
  - A requester holds `req_valid` and its operands stable until `req_ready`.
  - Dropping `req_valid` before the grant withdraws the request and is legal.
  - A requester may issue a new request only after its `resp_valid`.
- **CALC:**
  - Each cycle with `mult_en`=1, process bit `step` of b: if the bit is set, add sign-extended (a << step) into the 2*WIDTH accumulator; then step++.
  - Cycles with `mult_en`=0 hold all state.
  - After step WIDTH-1 is processed, go to DONE.
- **DONE:** latch the accumulator into `resp_p`, pulse `resp_valid[g]` for one cycle, then return to IDLE.
- **Arithmetic:**
  - Exact full-precision signed(a) × unsigned(b); no saturation, no rounding.
  - The accumulator wraps modulo 2^(2*WIDTH), which is unreachable for in-range operands.
- **`overrun`:**
  - Set when `sample_tick`=1 while `busy`=1, or while any `req_valid` bit is high in IDLE.
  - Stays set until `rst`.
- **`sample_tick`** does not otherwise alter arbitration or an operation in progress.
- **Reset:** asynchronous `rst` at any time, including mid-CALC, aborts the operation with no response. FSM goes to IDLE, `rr_ptr`=0, and all outputs go to 0.

## Timing
- Reset values:
  - `req_ready`=0, `resp_valid`=0
  - `resp_p`=0, `busy`=0, `overrun`=0
- Grant cycle T0: `req_ready` is high; `busy` rises at T0+1.
- With `mult_en` tied high:
  - CALC occupies T0+1..T0+WIDTH.
  - DONE at T0+WIDTH+1: `resp_valid` high, with `resp_p` updated at the same edge.
  - IDLE at T0+WIDTH+2; the earliest next `req_ready` is in that same cycle.
- General case: latency from grant to `resp_valid` is 1 + (cycles needed to see WIDTH `mult_en` pulses) + 0.
- `mult_en` is ignored in IDLE and DONE.
- `resp_p` is stable from DONE until the next DONE.
- `req_ready` and `resp_valid` are never high for more than one cycle per transaction, and never for two requesters at once.
- Simultaneous requests resolve by `rr_ptr` only. A request arriving in DONE waits for IDLE.

## Test plan
- **Basic product:** `rst` pulse; `mult_en`=1; requester 0 with a=3, b=5. Expect `req_ready[0]` at grant cycle T0, `resp_valid[0]` at T0+17, `resp_p`=15.
- **Signed and extreme operands:** a=-32768, b=65535 → `resp_p`=-2147450880 (0x80008000). a=-1, b=1 → 0xFFFFFFFF.
- **Slow enable:** `mult_en` pulsing 1-in-4. a=100, b=200 → `resp_valid` after 16 enable pulses (about 64 cycles), `resp_p`=20000. State holds between pulses.
- **Round-robin:** all three requesters valid continuously, each with a distinct a and b=1. Grant order 0,1,2,0,1,2. Each `resp_p` equals its own a; no two grants overlap.
- **Overrun:** `sample_tick` during CALC → `overrun`=1, and it stays 1 across later clean frames. `sample_tick` in IDLE with no requests after a fresh reset → `overrun` stays 0.
- **Reset mid-operation:** assert `rst` at CALC step 7 → all outputs 0 immediately, no `resp_valid`. After release, a new request from requester 2 with a=7, b=6 is granted (`rr_ptr`=0 search) and returns 42.
